// File: rtl/lockin_fp_mac_sequencer_pkg.sv
// Shared types for the lock-in MAC sequencer: ALU opcodes, FSM states and
// float32 constants and helpers.
package lockin_fp_mac_sequencer_pkg;

    typedef enum logic [1:0] {
        FADD = 2'd0,
        FMUL = 2'd1
    } alu_instruction_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        MUL_I   = 3'd1,
        ADD_I   = 3'd2,
        MUL_Q   = 3'd3,
        ADD_Q   = 3'd4,
        SCALE_I = 3'd5,
        SCALE_Q = 3'd6,
        OUT     = 3'd7
    } mac_state_t;

    localparam logic [31:0] FP_ZERO = 32'h0000_0000;
    localparam logic [31:0] FP_ONE  = 32'h3F80_0000;

    // Any float with a zero exponent field (zero or subnormal) counts as zero.
    function automatic logic fp_is_zero(input logic [31:0] f);
        return f[30:23] == 8'h00;
    endfunction

endpackage

// File: rtl/lockin_fp_mac_sequencer_if.sv
// Bundle of the sample input, ALU operand/result and I/Q output channels
// seen by the lock-in MAC sequencer.
interface lockin_fp_mac_sequencer_if;
    import lockin_fp_mac_sequencer_pkg::*;

    // Both streams use valid/ready: a transfer happens on a clock edge where
    // valid and ready are both high; the payload must be held stable while
    // valid is high and ready is low, and valid never waits on ready.
    logic             sample_valid;
    logic             sample_ready;
    logic [31:0]      sample_data;
    logic [31:0]      ref_cos;
    logic [31:0]      ref_sin;

    logic [31:0]      alu_op1;
    logic [31:0]      alu_op2;
    alu_instruction_t alu_instruction;
    logic [31:0]      alu_result;

    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_i;
    logic [31:0]      out_q;

    modport master (
        input  sample_valid, sample_data, ref_cos, ref_sin, alu_result, out_ready,
        output sample_ready, alu_op1, alu_op2, alu_instruction, out_valid, out_i, out_q
    );

    modport slave (
        output sample_valid, sample_data, ref_cos, ref_sin, alu_result, out_ready,
        input  sample_ready, alu_op1, alu_op2, alu_instruction, out_valid, out_i, out_q
    );

endinterface

// File: rtl/lockin_fp_mac_sequencer.sv
// Lock-in I/Q accumulator that sequences one float op per cycle through an
// external combinational ALU: I = SCALE*sum(s*cos), Q = SCALE*sum(s*sin).
module lockin_fp_mac_sequencer
    import lockin_fp_mac_sequencer_pkg::*;
#(
    parameter int unsigned N_SAMPLES = 1024,
    parameter logic [31:0] SCALE     = 32'h3A80_0000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    lockin_fp_mac_sequencer_if.master bus,
    output mac_state_t                dbg_state
);

    localparam int unsigned     CNT_W = $clog2(N_SAMPLES + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_SAMPLES - 1);

    mac_state_t       state;
    logic [CNT_W-1:0] count;
    logic [31:0]      s_q, cos_q, sin_q;
    logic [31:0]      prod, acc_i, acc_q;
    logic             prod_zero, acc_i_zero, acc_q_zero;
    logic             sample_ready, out_valid;
    logic [31:0]      out_i, out_q;
    logic [31:0]      op1, op2;
    alu_instruction_t instr;

    // A skipped multiply (no FMUL issued) or an underflowed product is zero.
    logic        mul_zero;
    logic [31:0] mul_val;
    logic        res_zero;
    logic [31:0] res_val;

    assign mul_zero = (instr != FMUL) || fp_is_zero(bus.alu_result);
    assign mul_val  = mul_zero ? FP_ZERO : bus.alu_result;
    assign res_zero = fp_is_zero(bus.alu_result);
    assign res_val  = res_zero ? FP_ZERO : bus.alu_result;

    // Operands are registered one edge ahead so they are valid for the whole
    // cycle of the state that consumes the ALU result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            count        <= '0;
            s_q          <= FP_ZERO;
            cos_q        <= FP_ZERO;
            sin_q        <= FP_ZERO;
            prod         <= FP_ZERO;
            prod_zero    <= 1'b1;
            acc_i        <= FP_ZERO;
            acc_q        <= FP_ZERO;
            acc_i_zero   <= 1'b1;
            acc_q_zero   <= 1'b1;
            sample_ready <= 1'b0;
            out_valid    <= 1'b0;
            out_i        <= FP_ZERO;
            out_q        <= FP_ZERO;
            op1          <= FP_ZERO;
            op2          <= FP_ZERO;
            instr        <= FADD;
        end else begin
            op1          <= FP_ZERO;
            op2          <= FP_ZERO;
            instr        <= FADD;
            sample_ready <= 1'b0;
            case (state)
                IDLE: begin
                    sample_ready <= 1'b1;
                    if (bus.sample_valid && sample_ready) begin
                        s_q          <= bus.sample_data;
                        cos_q        <= bus.ref_cos;
                        sin_q        <= bus.ref_sin;
                        sample_ready <= 1'b0;
                        state        <= MUL_I;
                        if (!fp_is_zero(bus.sample_data) && !fp_is_zero(bus.ref_cos)) begin
                            op1   <= bus.sample_data;
                            op2   <= bus.ref_cos;
                            instr <= FMUL;
                        end
                    end
                end
                MUL_I: begin
                    prod      <= mul_val;
                    prod_zero <= mul_zero;
                    state     <= ADD_I;
                    if (!mul_zero && !acc_i_zero) begin
                        op1   <= acc_i;
                        op2   <= mul_val;
                        instr <= FADD;
                    end
                end
                ADD_I: begin
                    if (!prod_zero) begin
                        acc_i      <= acc_i_zero ? prod : res_val;
                        acc_i_zero <= acc_i_zero ? 1'b0 : res_zero;
                    end
                    state <= MUL_Q;
                    if (!fp_is_zero(s_q) && !fp_is_zero(sin_q)) begin
                        op1   <= s_q;
                        op2   <= sin_q;
                        instr <= FMUL;
                    end
                end
                MUL_Q: begin
                    prod      <= mul_val;
                    prod_zero <= mul_zero;
                    state     <= ADD_Q;
                    if (!mul_zero && !acc_q_zero) begin
                        op1   <= acc_q;
                        op2   <= mul_val;
                        instr <= FADD;
                    end
                end
                ADD_Q: begin
                    if (!prod_zero) begin
                        acc_q      <= acc_q_zero ? prod : res_val;
                        acc_q_zero <= acc_q_zero ? 1'b0 : res_zero;
                    end
                    count <= count + 1'b1;
                    if (count == LAST) begin
                        state <= SCALE_I;
                        if (!acc_i_zero) begin
                            op1   <= acc_i;
                            op2   <= SCALE;
                            instr <= FMUL;
                        end
                    end else begin
                        state        <= IDLE;
                        sample_ready <= 1'b1;
                    end
                end
                SCALE_I: begin
                    out_i <= acc_i_zero ? FP_ZERO : bus.alu_result;
                    state <= SCALE_Q;
                    if (!acc_q_zero) begin
                        op1   <= acc_q;
                        op2   <= SCALE;
                        instr <= FMUL;
                    end
                end
                SCALE_Q: begin
                    out_q     <= acc_q_zero ? FP_ZERO : bus.alu_result;
                    out_valid <= 1'b1;
                    state     <= OUT;
                end
                OUT: begin
                    if (bus.out_ready) begin
                        out_valid    <= 1'b0;
                        acc_i        <= FP_ZERO;
                        acc_q        <= FP_ZERO;
                        acc_i_zero   <= 1'b1;
                        acc_q_zero   <= 1'b1;
                        count        <= '0;
                        sample_ready <= 1'b1;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.sample_ready    = sample_ready;
    assign bus.alu_op1         = op1;
    assign bus.alu_op2         = op2;
    assign bus.alu_instruction = instr;
    assign bus.out_valid       = out_valid;
    assign bus.out_i           = out_i;
    assign bus.out_q           = out_q;
    assign dbg_state           = state;

endmodule

// File: tb/tb_lockin_fp_mac_sequencer.sv
// Bench for the lock-in MAC sequencer: behavioural float ALU, real-valued
// I/Q reference model and directed plus randomized frames.
module tb_lockin_fp_mac_sequencer;
    import lockin_fp_mac_sequencer_pkg::*;

    localparam int          N     = 4;
    localparam logic [31:0] SCALE = 32'h3E80_0000;
    localparam logic [31:0] VALS [10] = '{
        32'h0000_0000, 32'h0000_0123, 32'h3F00_0000, 32'h3F80_0000, 32'h3FC0_0000,
        32'h4000_0000, 32'h3E80_0000, 32'hBF80_0000, 32'hBF00_0000, 32'hC000_0000
    };

    // ---------------- clock / reset / DUT ----------------
    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    mac_state_t dbg_state;
    int         cyc   = 0;

    lockin_fp_mac_sequencer_if bus ();

    lockin_fp_mac_sequencer #(.N_SAMPLES(N), .SCALE(SCALE)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- float helpers and behavioural ALU ----------------
    function automatic real f2r(input logic [31:0] f);
        real m;
        int  e;
        if (f[30:23] == 8'h00) return 0.0;
        m = 1.0 + f[22:0] / 8388608.0;
        e = int'(f[30:23]) - 127;
        while (e > 0) begin m = m * 2.0; e--; end
        while (e < 0) begin m = m / 2.0; e++; end
        return f[31] ? -m : m;
    endfunction

    function automatic logic [31:0] r2f(input real v);
        real  a;
        int   e;
        logic s;
        if (v == 0.0) return 32'h0;
        s = (v < 0.0);
        a = s ? -v : v;
        e = 0;
        while (a >= 2.0) begin a = a / 2.0; e++; end
        while (a < 1.0)  begin a = a * 2.0; e--; end
        return {s, 8'(e + 127), 23'($rtoi((a - 1.0) * 8388608.0))};
    endfunction

    always_comb begin
        if (bus.alu_instruction == FMUL)
            bus.alu_result = r2f(f2r(bus.alu_op1) * f2r(bus.alu_op2));
        else
            bus.alu_result = r2f(f2r(bus.alu_op1) + f2r(bus.alu_op2));
    end

    // Any issued op (anything other than the idle 0,0,FADD pattern) must have nonzero operands.
    int zero_issues = 0;
    always @(negedge clk) begin
        if (rst_n && (bus.alu_instruction == FMUL || bus.alu_op1 != 32'h0 || bus.alu_op2 != 32'h0))
            if (bus.alu_op1[30:23] == 8'h00 || bus.alu_op2[30:23] == 8'h00)
                zero_issues++;
    end

    // ---------------- scoreboard / reference model ----------------
    logic [63:0] exp_q[$];
    real         sum_i      = 0.0;
    real         sum_q      = 0.0;
    int          n_in_frame = 0;
    int          n_checks   = 0;
    int          n_pass     = 0;
    int          last_acc_cyc = 0;

    task automatic model_add(input logic [31:0] s, input logic [31:0] c, input logic [31:0] sn);
        sum_i += f2r(s) * f2r(c);
        sum_q += f2r(s) * f2r(sn);
        n_in_frame++;
        if (n_in_frame == N) begin
            exp_q.push_back({r2f(sum_i * f2r(SCALE)), r2f(sum_q * f2r(SCALE))});
            sum_i      = 0.0;
            sum_q      = 0.0;
            n_in_frame = 0;
        end
    endtask

    task automatic model_reset();
        sum_i      = 0.0;
        sum_q      = 0.0;
        n_in_frame = 0;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] rnd_val();
        return VALS[$urandom_range(0, 9)];
    endfunction

    // ---------------- driver tasks ----------------
    // Presents a bundle and returns #1 after the accepting edge; valid stays high.
    task automatic push(input logic [31:0] s, input logic [31:0] c, input logic [31:0] sn,
                        input bit chk_gap);
        int waited = 0;
        int prev   = last_acc_cyc;
        bus.sample_data  = s;
        bus.ref_cos      = c;
        bus.ref_sin      = sn;
        bus.sample_valid = 1'b1;
        while (!bus.sample_ready && waited < 60) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!bus.sample_ready) begin
            check("accept_timeout", 32'(bus.sample_ready), 32'd1);
            return;
        end
        @(posedge clk); #1;
        last_acc_cyc = cyc;
        model_add(s, c, sn);
        if (chk_gap) begin
            check("ready_low_cycles", 32'(waited), 32'd4);
            check("accept_gap", 32'(cyc - prev), 32'd5);
        end
    endtask

    task automatic gap_cycles(input int n);
        bus.sample_valid = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic collect(input bit chk_lat, input int hold);
        int          edges = 0;
        int          bad   = 0;
        logic [63:0] e;
        logic [31:0] si, sq;
        bus.sample_valid = 1'b0;
        while (!bus.out_valid && edges < 40) begin
            @(posedge clk); #1;
            edges++;
        end
        if (chk_lat) check("out_latency", 32'(edges), 32'd6);
        if (!bus.out_valid) begin
            check("out_timeout", 32'(bus.out_valid), 32'd1);
            return;
        end
        if (exp_q.size() == 0) begin
            check("exp_q_empty", 32'(exp_q.size()), 32'd1);
            return;
        end
        e = exp_q.pop_front();
        check("out_i", bus.out_i, e[63:32]);
        check("out_q", bus.out_q, e[31:0]);
        si = bus.out_i;
        sq = bus.out_q;
        repeat (hold) begin
            @(posedge clk); #1;
            if (!bus.out_valid || bus.out_i !== si || bus.out_q !== sq || bus.sample_ready) bad++;
        end
        if (hold > 0) check("hold_stable", 32'(bad), 32'd0);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check("out_valid_drop", 32'(bus.out_valid), 32'd0);
        check("idle_after_out", 32'(bus.sample_ready), 32'd1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ready"}, 32'(bus.sample_ready), 32'd0);
        check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_out_i"}, bus.out_i, 32'h0);
        check({tag, "_out_q"}, bus.out_q, 32'h0);
        check({tag, "_op1"}, bus.alu_op1, 32'h0);
        check({tag, "_op2"}, bus.alu_op2, 32'h0);
        check({tag, "_instr"}, 32'(bus.alu_instruction), 32'(FADD));
        check({tag, "_state"}, 32'(dbg_state), 32'(IDLE));
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        bus.sample_valid = 1'b0;
        bus.sample_data  = 32'h0;
        bus.ref_cos      = 32'h0;
        bus.ref_sin      = 32'h0;
        bus.out_ready    = 1'b0;
        rst_n            = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("ready_after_reset", 32'(bus.sample_ready), 32'd1);

        // 1.0 * {1.0, 0.5}, valid held high for the whole frame
        push(32'h3F80_0000, 32'h3F80_0000, 32'h3F00_0000, 1'b0);
        for (int k = 1; k < N; k++) push(32'h3F80_0000, 32'h3F80_0000, 32'h3F00_0000, 1'b1);
        collect(1'b1, 0);

        // zero sine reference: Q stays zero, no zero operand reaches the ALU
        for (int k = 0; k < N; k++) push(32'h3F80_0000, 32'h4000_0000, 32'h0000_0000, k > 0);
        collect(1'b1, 0);
        check("zero_operand_ops", 32'(zero_issues), 32'd0);

        // output held by back-pressure, then a fresh frame starting from zero
        for (int k = 0; k < N; k++) push(rnd_val(), rnd_val(), rnd_val(), 1'b0);
        collect(1'b0, 10);
        for (int k = 0; k < N; k++) push(rnd_val(), rnd_val(), rnd_val(), 1'b0);
        collect(1'b0, 0);

        // reset while sample 3 is in ADD_I discards the partial frame
        push(rnd_val(), rnd_val(), rnd_val(), 1'b0);
        push(rnd_val(), rnd_val(), rnd_val(), 1'b0);
        push(rnd_val(), rnd_val(), rnd_val(), 1'b0);
        bus.sample_valid = 1'b0;
        @(posedge clk); #1;
        check("pre_reset_state", 32'(dbg_state), 32'(ADD_I));
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_reset_values("mid_reset");
        model_reset();
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("ready_after_mid_reset", 32'(bus.sample_ready), 32'd1);
        for (int k = 0; k < N; k++) push(32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, k > 0);
        collect(1'b1, 0);

        // alternating +1/-1 cancels to an exact zero I
        for (int k = 0; k < N; k++)
            push((k % 2 == 0) ? 32'h3F80_0000 : 32'hBF80_0000, 32'h3F80_0000, rnd_val(), k > 0);
        collect(1'b1, 0);

        // randomized frames with random input gaps and output delays
        for (int f = 0; f < 6; f++) begin
            for (int k = 0; k < N; k++) begin
                push(rnd_val(), rnd_val(), rnd_val(), 1'b0);
                gap_cycles($urandom_range(0, 3));
            end
            collect(1'b0, $urandom_range(0, 3));
        end

        check("zero_operand_ops_final", 32'(zero_issues), 32'd0);
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
